pipe_stage_elastic: RTL and testbench



---
 rtl/pipe_stage_elastic.sv | 143 ++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register: valid/ready handshake, optional
// two-entry skid buffer, internal flush/bubble handling and saturating
// stall/kill counters for the performance monitor.
module pipe_stage_elastic #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned CTRL_W       = 16,
    parameter int unsigned SKID         = 1,
    parameter int unsigned ZERO_ON_KILL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    input  logic              cnt_clr,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       kill_cnt
);

    localparam int unsigned CNT_W = 16;

    logic              m_valid, m_valid_n;
    logic [CTRL_W-1:0] m_ctrl,  m_ctrl_n;
    logic [DATA_W-1:0] m_data,  m_data_n;
    logic              s_valid, s_valid_n;
    logic [CTRL_W-1:0] s_ctrl,  s_ctrl_n;
    logic [DATA_W-1:0] s_data,  s_data_n;
    logic              push, pop;
    logic              stall_inc, kill_inc;

    // Handshake: skid variant only needs S free; single-entry variant lets a pop make room
    always_comb begin
        if (SKID != 0) begin
            in_ready = !s_valid && !flush;
        end else begin
            in_ready = (!m_valid || out_ready) && !flush;
        end
        push = in_valid && in_ready;
        pop  = m_valid && out_ready && !flush;
    end

    assign out_valid = m_valid;
    assign out_ctrl  = m_valid ? m_ctrl : '0;
    assign out_data  = m_data;
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

    // Next-state for main and skid entries; flush overrides any push or pop
    always_comb begin
        m_valid_n = m_valid;
        m_ctrl_n  = m_ctrl;
        m_data_n  = m_data;
        s_valid_n = s_valid;
        s_ctrl_n  = s_ctrl;
        s_data_n  = s_data;
        if (flush) begin
            m_valid_n = 1'b0;
            s_valid_n = 1'b0;
            if (ZERO_ON_KILL != 0) begin
                m_ctrl_n = '0;
                m_data_n = '0;
                s_ctrl_n = '0;
                s_data_n = '0;
            end
        end else if (pop) begin
            if (s_valid) begin
                m_ctrl_n  = s_ctrl;
                m_data_n  = s_data;
                s_valid_n = 1'b0;
                if (ZERO_ON_KILL != 0) begin
                    s_ctrl_n = '0;
                    s_data_n = '0;
                end
            end else if (push) begin
                m_ctrl_n = in_ctrl;
                m_data_n = in_data;
            end else begin
                m_valid_n = 1'b0;
                if (ZERO_ON_KILL != 0) begin
                    m_ctrl_n = '0;
                    m_data_n = '0;
                end
            end
        end else if (push) begin
            if (!m_valid) begin
                m_valid_n = 1'b1;
                m_ctrl_n  = in_ctrl;
                m_data_n  = in_data;
            end else if (SKID != 0) begin
                s_valid_n = 1'b1;
                s_ctrl_n  = in_ctrl;
                s_data_n  = in_data;
            end
        end
    end

    // Entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_ctrl  <= '0;
            m_data  <= '0;
            s_valid <= 1'b0;
            s_ctrl  <= '0;
            s_data  <= '0;
        end else begin
            m_valid <= m_valid_n;
            m_ctrl  <= m_ctrl_n;
            m_data  <= m_data_n;
            s_valid <= s_valid_n;
            s_ctrl  <= s_ctrl_n;
            s_data  <= s_data_n;
        end
    end

    assign stall_inc = m_valid && !out_ready;
    assign kill_inc  = flush && (m_valid || s_valid);

    // Saturating performance counters; clear beats increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            kill_cnt  <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            kill_cnt  <= '0;
        end else begin
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (kill_inc && (kill_cnt != {CNT_W{1'b1}})) begin
                kill_cnt <= kill_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: a skid instance (index 0) and a single-entry
// instance (index 1) share stimulus; each is compared against a FIFO model.
module tb_pipe_stage_elastic;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;
    localparam int unsigned BW = CW + DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush, in_valid, out_ready, cnt_clr;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          in_ready0, out_valid0, in_ready1, out_valid1;
    logic [CW-1:0] out_ctrl0, out_ctrl1;
    logic [DW-1:0] out_data0, out_data1;
    logic [1:0]    occ0, occ1;
    logic [15:0]   stall0, stall1, kill0, kill1;

    logic          irdy [2];
    logic          ov   [2];
    logic [CW-1:0] oc   [2];
    logic [DW-1:0] od   [2];
    logic [1:0]    occ  [2];
    logic [15:0]   stc  [2];
    logic [15:0]   klc  [2];

    // Reference model: per-instance FIFO of beats plus counter expectations
    logic [BW-1:0] mem [2][4];
    int unsigned   hd  [2];
    int unsigned   qn  [2];
    logic [15:0]   st_e [2];
    logic [15:0]   kl_e [2];
    logic          exp_rdy [2];
    int unsigned   cap [2];

    int  n_chk  = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .ZERO_ON_KILL(1)) u_dut_skid (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0), .out_data(out_data0),
        .occupancy(occ0), .cnt_clr(cnt_clr), .stall_cnt(stall0), .kill_cnt(kill0)
    );

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .ZERO_ON_KILL(1)) u_dut_single (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1), .out_data(out_data1),
        .occupancy(occ1), .cnt_clr(cnt_clr), .stall_cnt(stall1), .kill_cnt(kill1)
    );

    always_comb begin
        irdy[0] = in_ready0;  irdy[1] = in_ready1;
        ov[0]   = out_valid0; ov[1]   = out_valid1;
        oc[0]   = out_ctrl0;  oc[1]   = out_ctrl1;
        od[0]   = out_data0;  od[1]   = out_data1;
        occ[0]  = occ0;       occ[1]  = occ1;
        stc[0]  = stall0;     stc[1]  = stall1;
        klc[0]  = kill0;      klc[1]  = kill1;
    end

    task automatic chk(input string name, input int id, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, id, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            hd[i] = 0; qn[i] = 0; st_e[i] = '0; kl_e[i] = '0;
        end
    endtask

    // One cycle of stimulus; model push/flush/clear applied after the monitor's pop
    task automatic step(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic ordy, input logic fl, input logic clr);
        @(negedge clk);
        in_valid = iv; in_ctrl = c; in_data = d;
        out_ready = ordy; flush = fl; cnt_clr = clr;
        exp_rdy[0] = (qn[0] < 2) && !fl;
        exp_rdy[1] = ((qn[1] == 0) || ordy) && !fl;
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("in_ready", i, 64'(irdy[i]), 64'(exp_rdy[i]));
            if (fl) begin
                if (qn[i] != 0) kl_e[i] = sat_inc(kl_e[i]);
                qn[i] = 0;
            end else if (iv && exp_rdy[i]) begin
                if (qn[i] >= cap[i]) begin
                    n_chk++; n_fail++;
                    $display("FAIL model_overflow dut%0d: got %0d entries expected below %0d", i, qn[i], cap[i]);
                end else begin
                    mem[i][(hd[i] + qn[i]) % 4] = {c, d};
                    qn[i]++;
                end
            end
            if (clr) begin
                st_e[i] = '0;
                kl_e[i] = '0;
            end
        end
    endtask

    // Monitor: check head/occupancy/counters, then retire a transfer
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                for (int i = 0; i < 2; i++) begin
                    logic [BW-1:0] head;
                    logic          ev;
                    ev   = (qn[i] != 0);
                    head = ev ? mem[i][hd[i]] : '0;
                    chk("out_valid", i, 64'(ov[i]), 64'(ev));
                    chk("occupancy", i, 64'(occ[i]), 64'(qn[i]));
                    chk("out_ctrl", i, 64'(oc[i]), 64'(head[BW-1:DW]));
                    chk("out_data", i, 64'(od[i]), 64'(head[DW-1:0]));
                    chk("stall_cnt", i, 64'(stc[i]), 64'(st_e[i]));
                    chk("kill_cnt", i, 64'(klc[i]), 64'(kl_e[i]));
                    if (ev && !out_ready) st_e[i] = sat_inc(st_e[i]);
                    if (ev && out_ready && !flush) begin
                        hd[i] = (hd[i] + 1) % 4;
                        qn[i]--;
                    end
                end
            end
        end
    end

    initial begin
        int piv, pord;
        cap[0] = 2; cap[1] = 1;
        model_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        in_ctrl = '0; in_data = '0;
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_out_valid", i, 64'(ov[i]), 64'd0);
            chk("rst_out_data", i, 64'(od[i]), 64'd0);
            chk("rst_occupancy", i, 64'(occ[i]), 64'd0);
            chk("rst_in_ready", i, 64'(irdy[i]), 64'd1);
        end
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Directed streaming 1..8 with out_ready high
        for (int k = 1; k <= 8; k++) step(1'b1, CW'(k), DW'(k), 1'b1, 1'b0, 1'b0);
        // Backpressure: A, B, C with out_ready low, then drain
        step(1'b1, 16'h00A0, 32'hA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h00B0, 32'hB, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 16'h00C0, 32'hC, 1'b0, 1'b0, 1'b0);
        repeat (4) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        // Flush with full stage and a beat offered, then flush when empty
        step(1'b1, 16'h1, 32'h1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h2, 32'h2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hD, 32'hD, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Randomised traffic with varying pressure
        for (int blk = 0; blk < 8; blk++) begin
            piv  = 30 + 10 * (blk % 7);
            pord = 20 + 11 * ((blk * 3) % 8);
            for (int k = 0; k < 400; k++) begin
                step(1'($urandom_range(0, 99) < piv), CW'($urandom), DW'($urandom),
                     1'($urandom_range(0, 99) < pord), 1'($urandom_range(0, 15) == 0),
                     1'($urandom_range(0, 63) == 0));
            end
        end

        // Stall counter saturation, then clear and resume counting
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 70000; k++) step(1'b1, CW'(k), DW'(k), 1'b0, 1'b0, 1'b0);
        step(1'b1, '0, '0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
        // Flush together with clear: kill must not count
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Async reset between edges with the skid instance full
        step(1'b1, 16'h11, 32'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h22, 32'h22, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h33, 32'h33, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_out_valid", i, 64'(ov[i]), 64'd0);
            chk("async_out_ctrl", i, 64'(oc[i]), 64'd0);
            chk("async_occupancy", i, 64'(occ[i]), 64'd0);
            chk("async_stall_cnt", i, 64'(stc[i]), 64'd0);
            chk("async_kill_cnt", i, 64'(klc[i]), 64'd0);
        end
        model_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        mon_en = 1'b1;
        for (int k = 0; k < 200; k++) begin
            step(1'($urandom_range(0, 1)), CW'($urandom), DW'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), 1'b0);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
